// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller around the execute stage: EX/MEM/WB destination scoreboard,
// per-operand forwarding selects, load-use stall and branch-flush sequencing.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal issue; detects flush requests and load-use hazards
// LDSTALL | consumer held one cycle while the load moves from EX to MEM
// FLUSH   | IF/ID killed and EX bubbled until the flush window expires
module pipeline_hazard_ctrl #(
    parameter int REG_BITS     = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [REG_BITS-1:0] dec_rn,
    input  logic [REG_BITS-1:0] dec_rm,
    input  logic [REG_BITS-1:0] dec_rd,
    input  logic                dec_use_rn,
    input  logic                dec_use_rm,
    input  logic                dec_use_rd,
    input  logic                dec_wr,
    input  logic                dec_load,
    input  logic                flush_req,
    output logic                stall_id,
    output logic                bubble_ex,
    output logic                kill_id,
    output logic [1:0]          fwd_rn,
    output logic [1:0]          fwd_rm,
    output logic [1:0]          fwd_rd,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_LDSTALL = 2'b01,
        ST_FLUSH   = 2'b10
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam state_t     ST_AFTER_REQ = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;

    state_t              state;
    logic [2:0]          cnt;

    logic                ex_v,  mem_v,  wb_v;
    logic                ex_ld;
    logic [REG_BITS-1:0] ex_dst, mem_dst, wb_dst;

    logic [2:0]          hit_rn, hit_rm, hit_rd;
    logic                hazard;

    // Returns {ex, mem, wb} match bits for one source operand.
    function automatic logic [2:0] stage_hits(input logic [REG_BITS-1:0] src,
                                              input logic                use_src);
        logic q;
        q = dec_valid & use_src;
        return {q & ex_v  & (ex_dst  == src),
                q & mem_v & (mem_dst == src),
                q & wb_v  & (wb_dst  == src)};
    endfunction

    // A load in EX cannot forward yet, so its match falls through to older stages.
    function automatic logic [1:0] fwd_select(input logic [2:0] hit);
        if (hit[2] && !ex_ld) return 2'b01;
        else if (hit[1])      return 2'b10;
        else if (hit[0])      return 2'b11;
        else                  return 2'b00;
    endfunction

    always_comb begin
        hit_rn = stage_hits(dec_rn, dec_use_rn);
        hit_rm = stage_hits(dec_rm, dec_use_rm);
        hit_rd = stage_hits(dec_rd, dec_use_rd);
        fwd_rn = fwd_select(hit_rn);
        fwd_rm = fwd_select(hit_rm);
        fwd_rd = fwd_select(hit_rd);
        hazard = ex_ld & (hit_rn[2] | hit_rm[2] | hit_rd[2]);
    end

    always_comb begin
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        kill_id   = 1'b0;
        case (state)
            ST_RUN: begin
                if (flush_req) begin
                    kill_id   = 1'b1;
                    bubble_ex = 1'b1;
                end else if (hazard) begin
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            ST_LDSTALL: begin
                if (flush_req) begin
                    kill_id   = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            ST_FLUSH: begin
                kill_id   = 1'b1;
                bubble_ex = 1'b1;
            end
            default: ;
        endcase
    end

    // cnt holds the FLUSH cycles still to run, including the current one,
    // so the request cycle plus cnt cycles gives FLUSH_CYCLES killed cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                ST_RUN, ST_LDSTALL: begin
                    if (flush_req) begin
                        cnt   <= CNT_LOAD;
                        state <= ST_AFTER_REQ;
                    end else if (state == ST_RUN && hazard) begin
                        state <= ST_LDSTALL;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (flush_req) begin
                        cnt   <= CNT_LOAD;
                        state <= ST_AFTER_REQ;
                    end else if (cnt <= 3'd1) begin
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        cnt   <= cnt - 3'd1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v    <= 1'b0;
            ex_dst  <= '0;
            ex_ld   <= 1'b0;
            mem_v   <= 1'b0;
            mem_dst <= '0;
            wb_v    <= 1'b0;
            wb_dst  <= '0;
        end else begin
            wb_v    <= mem_v;
            wb_dst  <= mem_dst;
            mem_v   <= ex_v;
            mem_dst <= ex_dst;
            if (dec_valid && dec_wr && !stall_id && !bubble_ex) begin
                ex_v   <= 1'b1;
                ex_dst <= dec_rd;
                ex_ld  <= dec_load;
            end else begin
                ex_v   <= 1'b0;
                ex_dst <= '0;
                ex_ld  <= 1'b0;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding, load-use stall,
// flush sequencing and reset abort, with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       dec_valid;
    logic [2:0] dec_rn, dec_rm, dec_rd;
    logic       dec_use_rn, dec_use_rm, dec_use_rd;
    logic       dec_wr, dec_load;
    logic       flush_req;
    logic       stall_id, bubble_ex, kill_id;
    logic [1:0] fwd_rn, fwd_rm, fwd_rd;
    logic [1:0] state_o;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.REG_BITS(3), .FLUSH_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .dec_valid  (dec_valid),
        .dec_rn     (dec_rn),
        .dec_rm     (dec_rm),
        .dec_rd     (dec_rd),
        .dec_use_rn (dec_use_rn),
        .dec_use_rm (dec_use_rm),
        .dec_use_rd (dec_use_rd),
        .dec_wr     (dec_wr),
        .dec_load   (dec_load),
        .flush_req  (flush_req),
        .stall_id   (stall_id),
        .bubble_ex  (bubble_ex),
        .kill_id    (kill_id),
        .fwd_rn     (fwd_rn),
        .fwd_rm     (fwd_rm),
        .fwd_rd     (fwd_rd),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_dec(input logic v, input logic [2:0] rn, input logic [2:0] rm,
                           input logic [2:0] rd, input logic urn, input logic urm,
                           input logic urd, input logic wr, input logic ld);
        dec_valid  = v;
        dec_rn     = rn;
        dec_rm     = rm;
        dec_rd     = rd;
        dec_use_rn = urn;
        dec_use_rm = urm;
        dec_use_rd = urd;
        dec_wr     = wr;
        dec_load   = ld;
    endtask

    task automatic nop();
        set_dec(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush_req = 1'b0;
        nop();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_state",  state_o,   2'd0);
        check("rst_stall",  {1'b0, stall_id},  2'd0);
        check("rst_bubble", {1'b0, bubble_ex}, 2'd0);
        check("rst_kill",   {1'b0, kill_id},   2'd0);
        tick();

        // ADD r1,r2,r3 then SUB r2,r1,r3 then CMP r2,r1
        set_dec(1, 3'd2, 3'd3, 3'd1, 1, 1, 0, 1, 0);
        @(negedge clk); check("add_fwd_rn", fwd_rn, 2'd0);
        tick();
        set_dec(1, 3'd1, 3'd3, 3'd2, 1, 1, 0, 1, 0);
        @(negedge clk);
        check("sub_fwd_rn", fwd_rn, 2'd1);
        check("sub_fwd_rm", fwd_rm, 2'd0);
        check("sub_stall",  {1'b0, stall_id}, 2'd0);
        tick();
        set_dec(1, 3'd2, 3'd1, 3'd0, 1, 1, 0, 0, 0);
        @(negedge clk);
        check("cmp_fwd_rn", fwd_rn, 2'd1);
        check("cmp_fwd_rm", fwd_rm, 2'd2);
        tick();

        // LDR r4,[r5] then ADD r5,r4,r4
        set_dec(1, 3'd5, 3'd0, 3'd4, 1, 0, 0, 1, 1);
        @(negedge clk);
        check("ldr_stall",  {1'b0, stall_id}, 2'd0);
        check("ldr_fwd_rn", fwd_rn, 2'd0);
        tick();
        set_dec(1, 3'd4, 3'd4, 3'd5, 1, 1, 0, 1, 0);
        @(negedge clk);
        check("lu_stall",  {1'b0, stall_id},  2'd1);
        check("lu_bubble", {1'b0, bubble_ex}, 2'd1);
        check("lu_state",  state_o, 2'd0);
        check("lu_fwd_rn", fwd_rn,  2'd0);
        tick();
        @(negedge clk);
        check("ls_state",  state_o, 2'd1);
        check("ls_stall",  {1'b0, stall_id},  2'd0);
        check("ls_bubble", {1'b0, bubble_ex}, 2'd0);
        check("ls_fwd_rn", fwd_rn,  2'd2);
        check("ls_fwd_rm", fwd_rm,  2'd2);
        tick();
        // EX holds the ADD, MEM the bubble, WB the load
        set_dec(1, 3'd5, 3'd4, 3'd0, 1, 1, 0, 0, 0);
        @(negedge clk);
        check("post_state",  state_o, 2'd0);
        check("post_fwd_rn", fwd_rn,  2'd1);
        check("post_fwd_rm", fwd_rm,  2'd3);
        tick();
        set_dec(0, 3'd5, 3'd5, 3'd5, 1, 1, 1, 1, 0);
        @(negedge clk);
        check("inv_fwd_rn", fwd_rn, 2'd0);
        check("inv_fwd_rd", fwd_rd, 2'd0);
        tick();

        // producer r6, two unrelated, store of r6
        set_dec(1, 3'd0, 3'd0, 3'd6, 0, 0, 0, 1, 0); tick();
        set_dec(1, 3'd0, 3'd0, 3'd7, 0, 0, 0, 1, 0); tick();
        set_dec(1, 3'd0, 3'd0, 3'd3, 0, 0, 0, 1, 0); tick();
        set_dec(1, 3'd0, 3'd0, 3'd6, 1, 0, 1, 0, 0);
        @(negedge clk);
        check("str_fwd_rd", fwd_rd, 2'd3);
        check("str_fwd_rn", fwd_rn, 2'd0);
        tick();
        set_dec(1, 3'd0, 3'd0, 3'd6, 0, 0, 0, 1, 0); tick();
        tick();
        set_dec(1, 3'd0, 3'd0, 3'd6, 1, 0, 1, 0, 0);
        @(negedge clk); check("str2_fwd_rd", fwd_rd, 2'd1);
        tick();

        // r0 is an ordinary register
        set_dec(1, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0); tick();
        set_dec(1, 3'd0, 3'd0, 3'd1, 1, 0, 0, 1, 0);
        @(negedge clk); check("r0_fwd_rn", fwd_rn, 2'd1);
        tick();
        nop(); tick(); tick(); tick();

        // isolated flush with a valid writer in decode
        set_dec(1, 3'd1, 3'd0, 3'd1, 1, 0, 0, 1, 0);
        flush_req = 1'b1;
        @(negedge clk);
        check("f0_kill",   {1'b0, kill_id},   2'd1);
        check("f0_bubble", {1'b0, bubble_ex}, 2'd1);
        check("f0_stall",  {1'b0, stall_id},  2'd0);
        check("f0_state",  state_o, 2'd0);
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        check("f1_kill",   {1'b0, kill_id},   2'd1);
        check("f1_bubble", {1'b0, bubble_ex}, 2'd1);
        check("f1_state",  state_o, 2'd2);
        tick();
        @(negedge clk);
        check("f2_kill",   {1'b0, kill_id},   2'd0);
        check("f2_bubble", {1'b0, bubble_ex}, 2'd0);
        check("f2_state",  state_o, 2'd0);
        check("f2_fwd_rn", fwd_rn,  2'd0);
        tick();
        nop(); tick(); tick(); tick();

        // flush together with a load-use hazard, then a second flush
        set_dec(1, 3'd0, 3'd0, 3'd4, 0, 0, 0, 1, 1); tick();
        set_dec(1, 3'd4, 3'd0, 3'd5, 1, 0, 0, 1, 0);
        flush_req = 1'b1;
        @(negedge clk);
        check("fh_kill",   {1'b0, kill_id},   2'd1);
        check("fh_stall",  {1'b0, stall_id},  2'd0);
        check("fh_bubble", {1'b0, bubble_ex}, 2'd1);
        tick();
        @(negedge clk);
        check("fh_state", state_o, 2'd2);
        check("fx0_kill", {1'b0, kill_id}, 2'd1);
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        check("fx1_state", state_o, 2'd2);
        check("fx1_kill",  {1'b0, kill_id}, 2'd1);
        tick();
        @(negedge clk);
        check("fx2_state", state_o, 2'd0);
        check("fx2_kill",  {1'b0, kill_id}, 2'd0);
        tick();
        nop(); tick();

        // reset while in FLUSH with valid scoreboard entries
        set_dec(1, 3'd0, 3'd0, 3'd1, 0, 0, 0, 1, 0); tick();
        set_dec(1, 3'd0, 3'd0, 3'd2, 0, 0, 0, 1, 0); tick();
        nop();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        rst = 1'b1;
        @(negedge clk); check("pre_rst_state", state_o, 2'd2);
        tick();
        rst = 1'b0;
        set_dec(1, 3'd2, 3'd1, 3'd0, 1, 1, 0, 0, 0);
        @(negedge clk);
        check("rs_state",  state_o, 2'd0);
        check("rs_kill",   {1'b0, kill_id},   2'd0);
        check("rs_bubble", {1'b0, bubble_ex}, 2'd0);
        check("rs_stall",  {1'b0, stall_id},  2'd0);
        check("rs_fwd_rn", fwd_rn, 2'd0);
        check("rs_fwd_rm", fwd_rm, 2'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
